// File: rtl/multi_inc_counter_if.sv
// multi_inc_counter_if -- control/data bundle for multi_inc_counter.
//   clr  : synchronous clear of count and flags
//   ld   : synchronous load of din into count
//   din  : load value (N bits)
//   cnt  : per-channel count enables (CH bits), each set bit adds 1
//   pout : registered count value (N bits)
//   co   : registered one-cycle carry pulse
//   ovf  : registered sticky overflow flag
//   busy : registered, previous cycle applied a nonzero increment
// Modports: master drives the controls and observes the results; slave is the counter.
interface multi_inc_counter_if #(
  parameter int N  = 5,
  parameter int CH = 2
);
  logic          clr;
  logic          ld;
  logic [N-1:0]  din;
  logic [CH-1:0] cnt;
  logic [N-1:0]  pout;
  logic          co;
  logic          ovf;
  logic          busy;

  modport master (
    output clr, ld, din, cnt,
    input  pout, co, ovf, busy
  );

  modport slave (
    input  clr, ld, din, cnt,
    output pout, co, ovf, busy
  );
endinterface

// File: rtl/multi_inc_counter.sv
// multi_inc_counter -- modulo-MOD counter advanced by the number of asserted
// count-enable channels per clock.
// Parameters: N (width), CH (channels, 1..MOD), MOD (modulus, 2..2**N).
// Ports:
//   clk : clock, all state updates on rising edge
//   rst : synchronous active-high reset
//   bus : multi_inc_counter_if.slave (clr, ld, din, cnt in; pout, co, ovf, busy out)
// Priority per edge: rst > clr > ld > count. All outputs are registered.
// Configuration macro MULTI_INC_COUNTER_SAT_EN: when defined, a crossing of
// the modulus saturates pout at MOD-1 instead of wrapping.
module multi_inc_counter #(
  parameter int N   = 5,
  parameter int CH  = 2,
  parameter int MOD = 2**N
) (
  input logic                 clk,
  input logic                 rst,
  multi_inc_counter_if.slave  bus
);

  localparam int IW = $clog2(CH + 1);
  localparam logic [N:0]   MODV = (N+1)'(MOD);
`ifdef MULTI_INC_COUNTER_SAT_EN
  localparam logic [N-1:0] MAXV = N'(MOD - 1);
`endif

  // Register initialisers give all-zero outputs before the first reset.
  logic [N-1:0] pout_q = '0;
  logic         co_q   = 1'b0;
  logic         ovf_q  = 1'b0;
  logic         busy_q = 1'b0;

  logic [IW-1:0] pc;
  logic [N:0]    inc;
  logic [N:0]    sum;
  logic [N:0]    din_x;

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      pc = pc + IW'(bus.cnt[i]);
    end
    inc   = (N+1)'(pc);
    sum   = {1'b0, pout_q} + inc;
    din_x = {1'b0, bus.din};
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      pout_q <= '0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else if (bus.ld) begin
      // A single subtraction folds an out-of-range load value back by MOD.
      pout_q <= (din_x >= MODV) ? N'(din_x - MODV) : bus.din;
      co_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= (inc != '0);
      if (sum >= MODV) begin
`ifdef MULTI_INC_COUNTER_SAT_EN
        // Already pinned at the ceiling: hold without a fresh carry pulse.
        if (pout_q == MAXV) begin
          co_q <= 1'b0;
        end else begin
          pout_q <= MAXV;
          co_q   <= 1'b1;
          ovf_q  <= 1'b1;
        end
`else
        pout_q <= N'(sum - MODV);
        co_q   <= 1'b1;
        ovf_q  <= 1'b1;
`endif
      end else begin
        pout_q <= sum[N-1:0];
        co_q   <= 1'b0;
      end
    end
  end

  assign bus.pout = pout_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/multi_inc_counter.md
MULTI_INC_COUNTER -- requirements
Module: multi_inc_counter

Interface
REQ-001 Parameter N, default 5: counter width in bits.
REQ-002 Parameter CH, default 2: number of count-enable channels; legal range 1..MOD.
REQ-003 Parameter MOD, default 2**N: counting modulus; legal range 2..2**N.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port clr, input, 1: synchronous clear of count and flags.
REQ-007 Port ld, input, 1: synchronous load of din into count.
REQ-008 Port din, input, N: load value.
REQ-009 Port cnt, input, CH: per-channel count enables; each asserted bit adds 1.
REQ-010 Port pout, output, N: registered count value.
REQ-011 Port co, output, 1: registered one-cycle carry pulse on modulus crossing.
REQ-012 Port ovf, output, 1: registered sticky flag, set by any carry.
REQ-013 Port busy, output, 1: registered; 1 when the previous cycle applied a nonzero increment.

Function
REQ-014 The increment inc shall be popcount(cnt), computed at width ceil(log2(CH+1)), zero-extended to N+1 bits.
REQ-015 Priority per edge: rst > clr > ld > count.
REQ-016 Count cycle: sum = pout + inc in N+1 bits.
REQ-017 If sum < MOD: pout <= sum and co <= 0.
REQ-018 If sum >= MOD: pout <= sum - MOD, co <= 1 and ovf <= 1 (wrap mode; see REQ-028).
REQ-019 co shall be high for exactly the cycle after a crossing and low otherwise; back-to-back crossings give back-to-back pulses.
REQ-020 inc = 0 shall hold pout and drive co <= 0.
REQ-021 ld: if din >= MOD, pout <= din - MOD; otherwise pout <= din. co <= 0, ovf holds, cnt is ignored that cycle.
REQ-022 clr: pout <= 0, co <= 0, ovf <= 0, busy <= 0, overriding ld and cnt.
REQ-023 busy <= (inc != 0) on count cycles; busy <= 0 on clr, ld or rst.
REQ-024 No combinational path shall exist from any input to any output.

Reset
REQ-025 rst shall set pout = 0, co = 0, ovf = 0 and busy = 0 on the next rising clk edge, regardless of clr, ld or cnt.
REQ-026 rst asserted mid-count shall discard any pending crossing; co shall not pulse for that cycle.
REQ-027 Before the first reset, all outputs shall power up as 0 via register initialisers.

Configuration
REQ-028 Macro MULTI_INC_COUNTER_SAT_EN defined: a count cycle with sum >= MOD shall set pout <= MOD-1, co <= 1 and ovf <= 1. Once pout = MOD-1, further nonzero increments shall keep pout at MOD-1 with co <= 0.
REQ-029 Macro MULTI_INC_COUNTER_SAT_EN undefined: wrap behaviour per REQ-018; no saturation logic shall be synthesised.

Verification
REQ-030 N=5, CH=2, MOD=32, rst, then cnt=2'b11 for 16 cycles -> pout reaches 0 on cycle 16, co pulses once, ovf=1.
REQ-031 pout=30, cnt=2'b11 (wrap build) -> pout=0, co=1 for one cycle. Same stimulus with SAT_EN defined -> pout=31, co=1; next cycle cnt=2'b11 -> pout=31, co=0.
REQ-032 MOD=10, CH=3, pout=8, cnt=3'b111 -> pout=1, co=1; then cnt=3'b000 -> pout=1, co=0, busy=0.
REQ-033 In the same cycle, clr=1, ld=1, din=7, cnt=2'b11 -> pout=0, ovf=0. The next cycle with ld=1 only -> pout=7, co=0.
REQ-034 rst=1 with ld=1 and cnt all ones at pout=MOD-1 -> all outputs 0, no co pulse. Deassert rst -> counting resumes from 0.
